// File: rtl/memory_arbiter_ctrl_if.sv
// Memory-side bundle between the processor's ihit/dhit request port, the
// arbiter and the single RAM port. The arbiter takes the slave view; the
// processor/RAM environment takes the master view.
interface memory_arbiter_ctrl_if;
    // instruction request side
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        ihit;
    // data request side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dhit;
    // RAM port
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    // status
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/memory_arbiter_ctrl.sv
// memory_arbiter_ctrl: arbitrates instruction-fetch and data requests onto a
// single RAM port. Data wins by default, but after MAX_D_STREAK consecutive
// data grants with a fetch waiting, one fetch is forced through. Each granted
// access ends in exactly one ihit/dhit pulse, or in a sticky error state on a
// RAM error or timeout.
module memory_arbiter_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_D_STREAK   = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    memory_arbiter_ctrl_if.slave bus
);
    localparam int WAIT_W   = $clog2(TIMEOUT_CYCLES);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  wr_q, wr_d;

    logic d_req;
    logic force_i;

    // A data request is any read or write; the fetch is forced once the
    // data streak has reached its limit while a fetch is still waiting.
    assign d_req   = bus.dREN | bus.dWEN;
    assign force_i = bus.iREN && (streak_q == STREAK_MAX);

    // Next-state, grant selection and RAM/hit outputs.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_d     = wr_q;

        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
        bus.ihit     = 1'b0;
        bus.iload    = 32'h0;
        bus.dhit     = 1'b0;
        bus.dload    = 32'h0;
        bus.err      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req && !force_i) begin
                    state_d = D_ACC;
                    addr_d  = bus.daddr;
                    data_d  = bus.dstore;
                    wr_d    = bus.dWEN;
                    wait_d  = '0;
                    // force_i keeps the streak below STREAK_MAX here, so the
                    // increment cannot overflow the saturation point.
                    streak_d = bus.iREN ? (streak_q + STREAK_W'(1)) : '0;
                end else if (bus.iREN) begin
                    state_d  = I_ACC;
                    addr_d   = bus.iaddr;
                    data_d   = 32'h0;
                    wr_d     = 1'b0;
                    wait_d   = '0;
                    streak_d = '0;
                end else begin
                    streak_d = '0;
                end
            end

            D_ACC: begin
                bus.ramREN   = ~wr_q;
                bus.ramWEN   = wr_q;
                bus.ramaddr  = addr_q;
                bus.ramstore = data_q;
                if (bus.ramstate == RAM_ERROR) begin
                    state_d = ERR;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    bus.dhit  = 1'b1;
                    bus.dload = wr_q ? 32'h0 : bus.ramload;
                    state_d   = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            I_ACC: begin
                bus.ramREN   = 1'b1;
                bus.ramaddr  = addr_q;
                bus.ramstore = data_q;
                if (bus.ramstate == RAM_ERROR) begin
                    state_d = ERR;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    bus.ihit  = 1'b1;
                    bus.iload = bus.ramload;
                    state_d   = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ERR: begin
                bus.err = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and latched request; async reset drops everything to idle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            streak_q <= '0;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
        end
    end
endmodule

// File: tb/tb_memory_arbiter_ctrl.sv
// Bench for memory_arbiter_ctrl: a behavioural RAM with programmable wait
// states, a scoreboard of expected hits, a vector table of single accesses and
// hand-written sequences for reset, contention, starvation and error paths.
module tb_memory_arbiter_ctrl;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int MAX_D_STREAK   = 4;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic CLK = 1'b0;
    logic nRST;

    memory_arbiter_ctrl_if bus();

    memory_arbiter_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_D_STREAK  (MAX_D_STREAK)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C01_0004;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    // ---------------- RAM model ----------------
    int ram_wait      = 0;
    bit ram_hold_busy = 1'b0;
    bit ram_err_2nd   = 1'b0;
    int ram_cnt       = 0;

    always @(posedge CLK) begin
        if (!nRST || !(bus.ramREN || bus.ramWEN) || bus.ramstate == RS_ACCESS)
            ram_cnt <= 0;
        else
            ram_cnt <= ram_cnt + 1;
    end

    always_comb begin
        bus.ramstate = RS_FREE;
        bus.ramload  = 32'h0;
        if (bus.ramREN || bus.ramWEN) begin
            if (ram_err_2nd && ram_cnt >= 1)               bus.ramstate = RS_ERROR;
            else if (ram_hold_busy || ram_cnt < ram_wait)  bus.ramstate = RS_BUSY;
            else                                           bus.ramstate = RS_ACCESS;
            // drive read data even for writes so dload gating is exercised
            bus.ramload = mem_word(bus.ramaddr);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input bit is_d, input bit wr, input logic [31:0] addr,
                            input logic [31:0] store, input logic [31:0] load);
        exp_t e;
        e.is_d = is_d; e.wr = wr; e.addr = addr; e.store = store; e.load = load;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (nRST && (bus.ihit || bus.dhit)) begin
            check("hit_exclusive", 32'(bus.ihit & bus.dhit), 32'h0);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_hit: ihit=%0b dhit=%0b, required no hit", bus.ihit, bus.dhit);
            end else begin
                e = exp_q.pop_front();
                check("hit_kind_dhit", 32'(bus.dhit), 32'(e.is_d));
                check("hit_ramaddr", bus.ramaddr, e.addr);
                check("hit_ramWEN", 32'(bus.ramWEN), 32'(e.wr));
                check("hit_ramREN", 32'(bus.ramREN), 32'(!e.wr));
                if (e.wr) check("hit_ramstore", bus.ramstore, e.store);
                if (e.is_d) check("hit_dload", bus.dload, e.load);
                else        check("hit_iload", bus.iload, e.load);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        bit          is_d;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] data;
        int          wt;
        logic [31:0] exp_load;
        int          exp_lat;
    } vec_t;

    task automatic idle_req();
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    task automatic do_reset();
        idle_req();
        ram_hold_busy = 1'b0;
        ram_err_2nd   = 1'b0;
        ram_wait      = 0;
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // One request from IDLE to its hit; checks latency and enable duration.
    task automatic run_access(input vec_t v, input string tag);
        int lat;
        int en_cyc;
        bit got;
        ram_wait = v.wt;
        push_exp(v.is_d, v.wen, v.addr, v.data, v.exp_load);
        if (v.is_d) begin
            bus.dREN = v.ren; bus.dWEN = v.wen; bus.daddr = v.addr; bus.dstore = v.data;
        end else begin
            bus.iREN = 1'b1; bus.iaddr = v.addr;
        end
        lat = 0; en_cyc = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge CLK);
            lat++;
            if (bus.ramREN || bus.ramWEN) en_cyc++;
            if (bus.ihit || bus.dhit) begin
                got = 1'b1;
                idle_req();
            end
        end
        idle_req();
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_enable_cycles"}, 32'(en_cyc), 32'(v.wt + 1));
        @(posedge CLK);
        #1;
    endtask

    vec_t tbl[6];

    initial begin
        int cyc;
        int en;
        int dh;
        int ih;
        int hits;
        int d_at;
        int i_at;
        bit got;
        vec_t rv;

        //            is_d ren  wen  addr          data          wt load          lat
        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        2, 32'h8C01_0004, 4};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h1111_2222, 0, 32'h0200_FDFF, 2};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0,         3};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0,        0, 32'h0044_FFBB, 2};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, 3, 32'h0,         5};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        5, 32'h0010_FFEF, 7};

        bus.iREN = 1'b0; bus.iaddr = 32'h0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h0; bus.dstore = 32'h0;
        nRST = 1'b1;
        #3 nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_ctrl_outputs",
              32'({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err}), 32'h0);
        check("reset_ramaddr", bus.ramaddr, 32'h0);
        check("reset_ramstore", bus.ramstore, 32'h0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // single accesses from the vector table
        for (int i = 0; i < 6; i++) run_access(tbl[i], $sformatf("vec%0d", i));

        // reset asserted in the middle of a stalled fetch
        bus.iREN = 1'b1; bus.iaddr = 32'h80; ram_hold_busy = 1'b1;
        repeat (3) @(negedge CLK);
        check("midreset_pre_ramREN", 32'(bus.ramREN), 32'h1);
        nRST = 1'b0;
        #1;
        check("midreset_ctrl_outputs",
              32'({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err}), 32'h0);
        check("midreset_ramaddr", bus.ramaddr, 32'h0);
        idle_req();
        ram_hold_busy = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("midreset_idle_after",
                  32'({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}), 32'h0);
        end
        @(posedge CLK);
        #1;

        // simultaneous fetch and data write: data first, fetch after one idle cycle
        ram_wait = 0;
        push_exp(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0);
        push_exp(1'b0, 1'b0, 32'h48, 32'h0, mem_word(32'h48));
        bus.iREN = 1'b1; bus.iaddr = 32'h48;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
        cyc = 0; d_at = -1; i_at = -1;
        while (i_at < 0 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (bus.dhit) begin d_at = cyc; bus.dWEN = 1'b0; end
            if (bus.ihit) begin i_at = cyc; bus.iREN = 1'b0; end
        end
        idle_req();
        check("simul_dhit_cycle", 32'(d_at), 32'd2);
        check("simul_ihit_cycle", 32'(i_at), 32'd4);
        @(posedge CLK);
        #1;

        // starvation guard: D,D,D,D,I repeating with zero-wait RAM
        ram_wait = 0;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) push_exp(1'b0, 1'b0, 32'h60, 32'h0, mem_word(32'h60));
            else            push_exp(1'b1, 1'b0, 32'h400, 32'h0, mem_word(32'h400));
        end
        bus.iREN = 1'b1; bus.iaddr = 32'h60;
        bus.dREN = 1'b1; bus.daddr = 32'h400; bus.dstore = 32'h0;
        cyc = 0; hits = 0; ih = 0;
        while (hits < 10 && cyc < 80) begin
            @(negedge CLK);
            cyc++;
            if (bus.ihit) ih++;
            if (bus.ihit || bus.dhit) begin
                hits++;
                if (hits == 10) idle_req();
            end
        end
        idle_req();
        check("streak_hits", 32'(hits), 32'd10);
        check("streak_ihits", 32'(ih), 32'd2);
        check("streak_cycles", 32'(cyc), 32'd20);
        @(posedge CLK);
        #1;

        // timeout on a fetch that never completes
        bus.iREN = 1'b1; bus.iaddr = 32'h80; ram_hold_busy = 1'b1;
        cyc = 0; en = 0; got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            if (bus.err) got = 1'b1;
            else if (bus.ramREN) en++;
        end
        check("timeout_enable_cycles", 32'(en), 32'(TIMEOUT_CYCLES));
        check("timeout_err_cycle", 32'(cyc), 32'(TIMEOUT_CYCLES + 2));
        idle_req();
        ram_hold_busy = 1'b0;
        bus.dREN = 1'b1; bus.daddr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("timeout_err_sticky", 32'(bus.err), 32'h1);
            check("timeout_err_quiet",
                  32'({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}), 32'h0);
        end
        do_reset();
        check("timeout_err_cleared", 32'(bus.err), 32'h0);

        // recovery after reset
        rv = '{1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h0044_FFBB, 3};
        run_access(rv, "recover");

        // RAM reports ERROR on the second access cycle of a data read
        ram_wait = 5; ram_err_2nd = 1'b1;
        bus.dREN = 1'b1; bus.daddr = 32'h500;
        cyc = 0; en = 0; dh = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (bus.dhit) dh++;
            if (bus.err) got = 1'b1;
            else if (bus.ramREN) en++;
        end
        idle_req();
        check("ramerr_enable_cycles", 32'(en), 32'd2);
        check("ramerr_err_cycle", 32'(cyc), 32'd4);
        check("ramerr_no_dhit", 32'(dh), 32'd0);
        repeat (2) @(negedge CLK);
        check("ramerr_err_sticky", 32'(bus.err), 32'h1);
        do_reset();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/memory_arbiter_ctrl.md
Name: memory_arbiter_ctrl

Overview:
Responder side of the processor's ihit/dhit memory interface, which feeds the hazard unit's pipeline enables.
- Arbitrates instruction-fetch and data requests onto the single RAM port.
- Data requests have priority, with a bounded starvation guard for instruction fetches.
- Generates single-cycle ihit/dhit pulses and a sticky error flag on RAM error or timeout.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed in an access state before declaring a timeout (min 2).
MAX_D_STREAK, 4, consecutive data grants allowed while iREN is pending before one instruction grant is forced (min 1).

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
iREN  input  1  instruction read request
iaddr  input  32  instruction address
iload  output  32  instruction read data, valid when ihit=1
ihit  output  1  instruction access complete pulse
dREN  input  1  data read request
dWEN  input  1  data write request (dREN and dWEN together: write wins)
daddr  input  32  data address
dstore  input  32  data write value
dload  output  32  data read data, valid when dhit=1
dhit  output  1  data access complete pulse
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
err  output  1  sticky error flag

Behaviour:
- FSM states: IDLE, D_ACC, I_ACC, ERR. Reset enters IDLE.
- Reset values: all outputs 0; wait counter 0; streak counter 0; latched address/data/op cleared.
- IDLE, grant selection:
  - Data grant when (dREN|dWEN), unless streak==MAX_D_STREAK and iREN=1 → I_ACC.
  - Otherwise data grant → D_ACC; latch daddr, dstore and op (write if dWEN).
  - Else if iREN → I_ACC; latch iaddr.
  - Else stay in IDLE.
- Streak counter: increments on each D grant while iREN=1; clears on any I grant or when iREN=0 in IDLE; saturates at MAX_D_STREAK.
- D_ACC:
  - Drive ramaddr=latched addr, ramstore=latched data, and ramWEN (write op) or ramREN (read op).
  - Hold these outputs stable until exit.
  - When ramstate==ACCESS: dhit=1 combinationally that cycle, dload=ramload (0 for writes), next state IDLE.
- I_ACC: same as D_ACC with ramREN only. On ACCESS: ihit=1, iload=ramload, next state IDLE.
- Latency: request seen in IDLE at cycle N; RAM enables asserted from cycle N+1; earliest hit at N+1. The IDLE turnaround between back-to-back accesses costs one cycle.
- ihit and dhit are never high in the same cycle. Each is high for exactly one cycle per granted access.
- Request withdrawn mid-access: the access completes on latched values and the hit still pulses. A started write is never aborted.
- Wait counter: clears on entry to an access state; increments each cycle in D_ACC/I_ACC without ACCESS.
- Error: ramstate==ERROR, or the counter reaching TIMEOUT_CYCLES-1 without ACCESS, → ERR. No hit is issued for that access.
- ERR: RAM enables 0, hits 0, err=1. Remains in ERR until nRST.
- Reset asserted mid-access: outputs drop to 0 asynchronously, the pending hit is lost, FSM returns to IDLE.

Test Plan:
- Reset: nRST=0 mid-operation with ramREN=1 → all outputs 0 immediately; after release, IDLE with no hit.
- Single instruction read: iREN=1, iaddr=0x40; RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C010004 → ramREN=1, ramaddr=0x40 for 3 cycles; ihit pulses once with iload=0x8C010004.
- Simultaneous requests: iREN=1 and dWEN=1, daddr=0x100, dstore=0xDEADBEEF → data write served first (ramWEN=1, dhit pulse); instruction served next, one IDLE cycle later.
- Starvation guard (MAX_D_STREAK=4): iREN and dREN held high, zero-wait RAM → dhit pattern D,D,D,D,I repeating; ihit high on every 5th hit.
- Timeout: iREN=1, ramstate held BUSY → after 16 cycles FSM enters ERR with err=1 and no ihit; err stays 1 until nRST.
- RAM ERROR: dREN=1, ramstate=ERROR on the 2nd cycle → ERR, dhit never asserted.
